// File: rtl/l2_mem_responder_if.sv
// Single-word L2 request/response bus between the bus controller (master)
// and the L2 responder (slave).
interface l2_mem_responder_if;
  logic        l2REN;
  logic        l2WEN;
  logic [31:0] l2addr;
  logic [31:0] l2store;
  logic [3:0]  l2_byte_en;
  logic [31:0] l2load;
  logic [1:0]  l2state;
  logic        l2error;

  modport master (
    output l2REN, l2WEN, l2addr, l2store, l2_byte_en,
    input  l2load, l2state, l2error
  );

  modport slave (
    input  l2REN, l2WEN, l2addr, l2store, l2_byte_en,
    output l2load, l2state, l2error
  );
endinterface

// File: rtl/l2_mem_responder.sv
// L2-side responder: word-addressed backing array with a fixed access
// latency, byte-lane writes, request validation and abort while busy.
module l2_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic                  CLK,
  input logic                  nRST,
  l2_mem_responder_if.slave    bus
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    L2_FREE   = 2'd0,
    L2_BUSY   = 2'd1,
    L2_ACCESS = 2'd2,
    L2_ERROR  = 2'd3
  } l2_state_t;

  l2_state_t   r_state, w_nstate;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_addr, r_store, r_load;
  logic [3:0]  r_be;
  logic        r_wr, r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_req, w_invalid, w_latch, w_rd, w_wr;
  logic [32:0] w_addr33, w_lo33, w_hi33;
  logic [31:0] w_c_addr, w_c_store, w_off;
  logic [3:0]  w_c_be;
  logic [AW-1:0] w_idx;

  assign w_req    = bus.l2REN | bus.l2WEN;
  assign w_addr33 = {1'b0, bus.l2addr};
  assign w_lo33   = {1'b0, BASE_ADDR};
  assign w_hi33   = w_lo33 + (33'(DEPTH_WORDS) << 2);
  assign w_invalid = (bus.l2REN & bus.l2WEN) | (bus.l2addr[1:0] != 2'b00) |
                     (w_addr33 < w_lo33) | (w_addr33 >= w_hi33);

  // With zero latency the access happens on the accepting edge, so the
  // live inputs feed the array instead of the latched copies.
  assign w_c_addr  = (r_state == L2_FREE) ? bus.l2addr     : r_addr;
  assign w_c_store = (r_state == L2_FREE) ? bus.l2store    : r_store;
  assign w_c_be    = (r_state == L2_FREE) ? bus.l2_byte_en : r_be;
  assign w_off     = w_c_addr - BASE_ADDR;
  assign w_idx     = AW'(w_off >> 2);

  always_comb begin
    w_nstate = r_state;
    w_latch  = 1'b0;
    w_rd     = 1'b0;
    w_wr     = 1'b0;
    case (r_state)
      L2_FREE: begin
        if (w_req) begin
          if (w_invalid) begin
            w_nstate = L2_ERROR;
          end else begin
            w_latch = 1'b1;
            if (LATENCY == 0) begin
              w_nstate = L2_ACCESS;
              w_rd     = bus.l2REN;
              w_wr     = bus.l2WEN;
            end else begin
              w_nstate = L2_BUSY;
            end
          end
        end
      end
      L2_BUSY: begin
        if (!w_req) begin
          w_nstate = L2_FREE;
        end else if (r_cnt == '0) begin
          w_nstate = L2_ACCESS;
          w_rd     = ~r_wr;
          w_wr     = r_wr;
        end
      end
      default: w_nstate = L2_FREE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= L2_FREE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_store <= '0;
      r_be    <= '0;
      r_wr    <= 1'b0;
      r_load  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_err   <= (w_nstate == L2_ERROR);
      if (w_latch) begin
        r_addr  <= bus.l2addr;
        r_store <= bus.l2store;
        r_be    <= bus.l2_byte_en;
        r_wr    <= bus.l2WEN;
        r_cnt   <= CW'((LATENCY > 0) ? LATENCY - 1 : 0);
      end else if (r_state == L2_BUSY && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_rd) r_load <= r_mem[w_idx];
    end
  end

  // Array is not reset; nRST gating keeps a reset edge from committing.
  always_ff @(posedge CLK) begin
    if (w_wr && nRST) begin
      for (int b = 0; b < 4; b++)
        if (w_c_be[b]) r_mem[w_idx][8*b +: 8] <= w_c_store[8*b +: 8];
    end
  end

  assign bus.l2state = r_state;
  assign bus.l2load  = r_load;
  assign bus.l2error = r_err;
endmodule

// File: doc/l2_mem_responder.md
Name: l2_mem_responder

Overview:
- Responder (L2 side) of the coherence bus controller's L2 port.
- Accepts single-word read/write requests on l2REN/l2WEN/l2addr/l2store/l2_byte_en and answers with l2state/l2load/l2error.
- Uses a word-addressed backing array with programmable access latency.
- Used as the L2 model behind the bus controller in multi-hart simulation/FPGA builds, and as the bench L2 for bus controller verification.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the backing array (power of two).
- LATENCY, 4, number of L2_BUSY cycles between request acceptance and L2_ACCESS (0 allowed).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0; must be word-aligned.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- nRST  input  1  asynchronous active-low reset.
- l2REN  input  1  read request, held by requester until L2_ACCESS or L2_ERROR is seen.
- l2WEN  input  1  write request, same hold rule.
- l2addr  input  32  byte address of request.
- l2store  input  32  write data.
- l2_byte_en  input  4  byte lane enables for writes; bit i covers l2store[8i+7:8i].
- l2load  output  32  read data, valid while l2state==L2_ACCESS after a read.
- l2state  output  2  l2_state_t: L2_FREE=0, L2_BUSY=1, L2_ACCESS=2, L2_ERROR=3.
- l2error  output  1  high exactly when l2state==L2_ERROR.

Behaviour:
- Clock is CLK; reset is nRST, asynchronous and active-low.
- Reset values: l2state=L2_FREE, l2load=0, l2error=0, latency counter=0, latched request cleared. Array contents are not reset; benches write before reading.
- l2state and l2error are registered directly from the FSM; no combinational input-to-output paths.
- FREE:
  - Request means l2REN|l2WEN.
  - Sampled at an edge with a valid request: latch addr, store, byte_en and the op.
  - LATENCY>0: go to BUSY with counter=LATENCY-1.
  - LATENCY==0: go straight to ACCESS.
- Invalid request, sampled in FREE: go to ERROR, nothing latched, no array access. Invalid means any of:
  - l2REN&l2WEN both set;
  - l2addr[1:0]!=0;
  - l2addr<BASE_ADDR or l2addr>=BASE_ADDR+4*DEPTH_WORDS (compare in 33 bits, no wrap).
- BUSY:
  - Counter decrements each cycle. At counter==0, go to ACCESS.
  - Input changes to addr, store or byte_en are ignored (latched copies are used).
  - Abort: if both l2REN and l2WEN are low at any BUSY edge, return to FREE. No write commit, l2load unchanged.
- ACCESS, held for exactly one cycle, then FREE unconditionally (requests held during ACCESS are ignored):
  - Read: l2load = array[idx], registered on the edge entering ACCESS.
  - Write: on the edge entering ACCESS, array[idx] is updated only in lanes with byte_en set. l2load is unchanged.
  - Index: idx = (latched_addr-BASE_ADDR)>>2, truncated to $clog2(DEPTH_WORDS) bits.
  - byte_en=0000 is a legal write that changes nothing.
- ERROR: one cycle with l2error=1, then FREE unconditionally.
- Request timing:
  - Minimum request-to-request spacing is one FREE cycle; back-to-back requests are accepted on the first FREE edge.
  - Total latency: request sampled at edge k gives ACCESS during cycle k+LATENCY+1.
- l2load holds the last read data through FREE/BUSY/ERROR.
- Reset asserted mid-BUSY: immediate return to reset values. An uncommitted write is lost; the array keeps prior contents.

Test Plan:
- Write 0xDEADBEEF to addr 0x40 with byte_en=1111, then read 0x40 (LATENCY=4). Required: 4 BUSY cycles then ACCESS each time; the read returns l2load=0xDEADBEEF in the ACCESS cycle; FREE on the next cycle.
- Byte lanes: with 0x11223344 already at 0x80, write 0xAABBCCDD with byte_en=0101, then read 0x80. Required: l2load=0x11BB33DD.
- Errors, each one cycle of L2_ERROR with l2error=1 then FREE, and the array unchanged:
  - l2REN=l2WEN=1 at addr 0x0;
  - read of 0x42;
  - read of BASE_ADDR+4*DEPTH_WORDS.
- Abort: start a write of 0x55 to 0x10 and drop l2WEN after 2 BUSY cycles. Required: FREE next cycle, no ACCESS; a later read of 0x10 returns the old value.
- LATENCY=0 instance: a read request sampled at edge k gives ACCESS during cycle k+1. Back-to-back reads of 0x0 and 0x4 give alternating ACCESS/FREE with the correct data.
- Reset: assert nRST low mid-BUSY of a write. Required: l2state=FREE, l2load=0 and l2error=0 immediately (asynchronously); a post-reset read shows the write did not commit.
